// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Two-state instruction fetch/issue sequencer with PC update,
//               jump/branch target selection and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IMEM_AW  = 32
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imemReq,
  output logic [IMEM_AW-1:0] imemAddr,
  input  logic               imemReady,
  input  logic [31:0]        imemData,
  output logic               instrValid,
  output logic [31:0]        instruction,
  input  logic               instrAccept,
  input  logic               jump,
  input  logic [1:0]         branch,
  input  logic               zero,
  input  logic               halt,
  output logic [31:0]        pc,
  output logic [31:0]        retired
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_stateNext;
  logic        r_reqActive;
  logic [31:0] r_pc;
  logic [31:0] r_instruction;
  logic [31:0] r_retired;

  logic        w_fire;
  logic        w_accept;
  logic        w_branchTaken;
  logic [31:0] w_pcPlus4;
  logic [31:0] w_jumpTarget;
  logic [31:0] w_branchTarget;
  logic [31:0] w_pcNext;

  // Once a request is on the bus it stays there until served, even if halt rises.
  assign imemReq     = reset && (r_state == FETCH) && (r_reqActive || !halt);
  assign imemAddr    = r_pc[IMEM_AW-1:0];
  assign instrValid  = (r_state == ISSUE);
  assign instruction = r_instruction;
  assign pc          = r_pc;
  assign retired     = r_retired;

  assign w_fire   = imemReq && imemReady;
  assign w_accept = (r_state == ISSUE) && instrAccept;

  assign w_pcPlus4      = r_pc + 32'd4;
  assign w_jumpTarget   = {w_pcPlus4[31:28], r_instruction[25:0], 2'b00};
  assign w_branchTarget = w_pcPlus4 + {{14{r_instruction[15]}}, r_instruction[15:0], 2'b00};
  assign w_branchTaken  = ((branch == 2'd1) && zero) || ((branch == 2'd2) && !zero);

  always_comb begin
    w_pcNext = w_pcPlus4;
    if (jump) begin
      w_pcNext = w_jumpTarget;
    end else if (w_branchTaken) begin
      w_pcNext = w_branchTarget;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      FETCH:   if (w_fire)   w_stateNext = ISSUE;
      ISSUE:   if (w_accept) w_stateNext = FETCH;
      default: w_stateNext = FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= FETCH;
      r_reqActive   <= 1'b0;
      r_pc          <= RESET_PC;
      r_instruction <= 32'h0000_0000;
      r_retired     <= 32'h0000_0000;
    end else begin
      r_state     <= w_stateNext;
      r_reqActive <= imemReq && !imemReady;
      if (w_fire) begin
        r_instruction <= imemData;
      end
      if (w_accept) begin
        r_pc      <= w_pcNext;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Randomized and directed scoreboard bench for fetch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady = 1'b0;
  logic [31:0] imemData = 32'h0;
  logic        instrValid;
  logic [31:0] instruction;
  logic        instrAccept = 1'b0;
  logic        jump = 1'b0;
  logic [1:0]  branch = 2'd0;
  logic        zero = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] pc;
  logic [31:0] retired;

  always #5 clock = ~clock;

  fetch_unit #(
    .RESET_PC (c_RESET_PC),
    .IMEM_AW  (32)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .imemReq     (imemReq),
    .imemAddr    (imemAddr),
    .imemReady   (imemReady),
    .imemData    (imemData),
    .instrValid  (instrValid),
    .instruction (instruction),
    .instrAccept (instrAccept),
    .jump        (jump),
    .branch      (branch),
    .zero        (zero),
    .halt        (halt),
    .pc          (pc),
    .retired     (retired)
  );

  int nTests = 0;
  int nFail  = 0;

  // Sparse instruction memory, filled with random words on first touch.
  logic [31:0] mem [logic [31:0]];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] retired;
  } issue_t;

  issue_t      expQ[$];
  logic [31:0] expPc;
  logic [31:0] expRetired;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = $urandom;
    return mem[a];
  endfunction

  function automatic void checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Next PC straight from the architectural rules.
  function automatic logic [31:0] refNextPc(input logic [31:0] curPc, input logic [31:0] ins,
                                            input logic j, input logic [1:0] br, input logic z);
    logic [31:0] seq;
    int          off;
    seq = curPc + 32'd4;
    off = int'($signed(ins[15:0])) * 4;
    if (j) return (seq & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if ((br == 2'd1 && z) || (br == 2'd2 && !z)) return seq + 32'(off);
    return seq;
  endfunction

  logic        pending = 1'b0;
  logic        prevValid = 1'b0;
  logic [31:0] prevAddr = 32'h0;
  logic [31:0] prevPc = 32'h0;
  logic [31:0] prevInstr = 32'h0;
  logic [31:0] prevRetired = 32'h0;

  function automatic void modelReset();
    issue_t e;
    expQ.delete();
    expPc      = c_RESET_PC;
    expRetired = 32'h0;
    e.pc       = c_RESET_PC;
    e.instr    = memRead(c_RESET_PC);
    e.retired  = 32'h0;
    expQ.push_back(e);
    pending    = 1'b0;
    prevValid  = 1'b0;
  endfunction

  always @(negedge clock) begin : p_monitor
    issue_t      e;
    logic [31:0] nxt;
    if (!reset) begin
      checkEq("reset_req", 32'(imemReq), 32'd0);
      checkEq("reset_valid", 32'(instrValid), 32'd0);
      modelReset();
    end else begin
      if (pending) begin
        checkEq("req_hold", 32'(imemReq), 32'd1);
        checkEq("addr_hold", imemAddr, prevAddr);
      end
      if (!instrValid) begin
        checkEq("fetch_pc", pc, expPc);
        if (!pending) checkEq("halt_gate", 32'(imemReq), 32'(!halt));
        if (imemReq) checkEq("req_addr", imemAddr, expPc);
      end else begin
        checkEq("issue_noreq", 32'(imemReq), 32'd0);
        if (!prevValid) begin
          if (expQ.size() == 0) begin
            checkEq("unexpected_issue", pc, 32'hFFFF_FFFF);
          end else begin
            e = expQ.pop_front();
            checkEq("issue_pc", pc, e.pc);
            checkEq("issue_instr", instruction, e.instr);
            checkEq("issue_retired", retired, e.retired);
          end
        end else begin
          checkEq("stall_pc", pc, prevPc);
          checkEq("stall_instr", instruction, prevInstr);
          checkEq("stall_retired", retired, prevRetired);
        end
        if (instrAccept) begin
          nxt        = refNextPc(expPc, memRead(expPc), jump, branch, zero);
          expRetired = expRetired + 32'd1;
          expPc      = nxt;
          e.pc       = nxt;
          e.instr    = memRead(nxt);
          e.retired  = expRetired;
          expQ.push_back(e);
        end
      end
      pending     = imemReq && !imemReady;
      prevValid   = instrValid;
      prevAddr    = imemAddr;
      prevPc      = pc;
      prevInstr   = instruction;
      prevRetired = retired;
    end
  end

  task automatic setIn(input logic rdy, input logic acc, input logic j,
                       input logic [1:0] br, input logic z, input logic h);
    imemReady   = rdy;
    instrAccept = acc;
    jump        = j;
    branch      = br;
    zero        = z;
    halt        = h;
    imemData    = rdy ? memRead(imemAddr) : $urandom;
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic drive(input logic rdy, input logic acc, input logic j,
                       input logic [1:0] br, input logic z, input logic h);
    setIn(rdy, acc, j, br, z, h);
    tick();
  endtask

  initial begin : p_stim
    logic [31:0] holdPc;
    logic [31:0] holdInstr;
    logic [31:0] holdRetired;
    mem[32'h20]  = 32'h1000_FFFE;
    mem[32'h40]  = 32'h0800_0100;
    mem[32'h400] = 32'h0800_0020;

    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkEq("first_req", 32'(imemReq), 32'd1);
    checkEq("first_addr", imemAddr, c_RESET_PC);

    // Zero-wait streaming: two cycles per instruction.
    repeat (8) drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    checkEq("stream_retired", retired, 32'd4);
    checkEq("stream_pc", pc, 32'h10);

    for (int i = 0; i < 3; i++) begin
      setIn(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
      #1;
      checkEq("wait_req", 32'(imemReq), 32'd1);
      checkEq("wait_addr", imemAddr, 32'h10);
      checkEq("wait_valid", 32'(instrValid), 32'd0);
      tick();
    end
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    checkEq("wait_capture", instruction, memRead(32'h10));

    repeat (8) drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    checkEq("beq_at", pc, 32'h20);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
    checkEq("beq_taken", pc, 32'h1C);
    repeat (3) drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    checkEq("beq_not_taken", pc, 32'h24);

    repeat (15) drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    checkEq("jump_at", pc, 32'h40);
    drive(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
    checkEq("jump_over_branch", pc, 32'h400);

    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    holdPc      = pc;
    holdInstr   = instruction;
    holdRetired = retired;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
      checkEq("stall_valid", 32'(instrValid), 32'd1);
      checkEq("stall_hold_pc", pc, holdPc);
      checkEq("stall_hold_instr", instruction, holdInstr);
      checkEq("stall_hold_retired", retired, holdRetired);
    end

    drive(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
    checkEq("halt_pc", pc, 32'h80);
    for (int i = 0; i < 3; i++) begin
      checkEq("halt_noreq", 32'(imemReq), 32'd0);
      drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    end
    setIn(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    #1;
    checkEq("unhalt_req", 32'(imemReq), 32'd1);
    tick();
    setIn(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    #1;
    checkEq("halt_no_abort", 32'(imemReq), 32'd1);
    tick();
    checkEq("halt_no_abort_addr", imemAddr, 32'h80);

    reset = 1'b0;
    #1;
    checkEq("async_req", 32'(imemReq), 32'd0);
    checkEq("async_valid", 32'(instrValid), 32'd0);
    checkEq("async_pc", pc, c_RESET_PC);
    checkEq("async_instr", instruction, 32'd0);
    checkEq("async_retired", retired, 32'd0);
    repeat (2) drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    checkEq("reset_ready_ignored", 32'(instrValid), 32'd0);
    reset = 1'b1;
    #1;
    checkEq("release_req", 32'(imemReq), 32'd1);
    checkEq("release_addr", imemAddr, c_RESET_PC);

    for (int i = 0; i < 4000; i++) begin
      drive(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 2));
    end
    @(negedge clock);
    checkEq("queue_drained", 32'(expQ.size() <= 1), 32'd1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
